ld_wb_release: RTL

Load-writeback release coalescer for the CGRA dispatcher. It drives the write-back (release) side of the dispatcher scoreboard. Per-thread load responses arrive as (TID, destination register) pairs. The block merges responses that target the same register into one TID bitmap and issues single-cycle release pulses (`wb_valid`, `wb_tid_bitmap`, `ld_dest_reg`) that clear the scoreboard reservations.

---
 rtl/ld_wb_release_if.sv | 24 ++
 rtl/ld_wb_release.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ld_wb_release_if.sv
// Load-response input and release-pulse output bundle of the write-back coalescer.
interface ld_wb_release_if #(
  parameter int NUM_TID = 256,
  parameter int TID_W   = 8,
  parameter int REG_W   = 7
);
  logic               ld_rsp_valid;
  logic               ld_rsp_ready;
  logic [TID_W-1:0]   ld_rsp_tid;
  logic [REG_W-1:0]   ld_rsp_reg;
  logic               wb_valid;
  logic [NUM_TID-1:0] wb_tid_bitmap;
  logic [REG_W-1:0]   ld_dest_reg;

  modport master (
    output ld_rsp_valid, ld_rsp_tid, ld_rsp_reg,
    input  ld_rsp_ready, wb_valid, wb_tid_bitmap, ld_dest_reg
  );

  modport slave (
    input  ld_rsp_valid, ld_rsp_tid, ld_rsp_reg,
    output ld_rsp_ready, wb_valid, wb_tid_bitmap, ld_dest_reg
  );
endinterface

// File: rtl/ld_wb_release.sv
// Coalesces per-thread load responses by destination register into TID bitmaps
// and emits one-cycle release pulses that clear scoreboard reservations.
module ld_wb_release #(
  parameter int NUM_TID  = 256,
  parameter int TID_W    = 8,
  parameter int REG_W    = 7,
  parameter int NUM_REGS = 34,
  parameter int DEPTH    = 4,
  parameter int HOLD     = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  ld_wb_release_if.slave   bus,
  input  logic             flush,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             idle,
  output logic             bad_reg
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = $clog2(HOLD + 1);

  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   vld_nxt;
  logic [REG_W-1:0]   regs    [DEPTH];
  logic [NUM_TID-1:0] bitmaps [DEPTH];
  logic [AGE_W-1:0]   ages    [DEPTH];

  logic               drain_en;
  logic               has_sel;
  logic               ripe;
  logic               hit;
  logic               has_free;
  logic               accept;
  logic               reg_ok;
  logic               do_merge;
  logic               do_alloc;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   free_idx;
  logic [AGE_W-1:0]   sel_age;
  logic [TID_W-1:0]   tid;
  logic [NUM_TID-1:0] tid_bit;
  logic [CNT_W-1:0]   cnt_nxt;

  assign tid              = bus.ld_rsp_tid;
  assign tid_bit          = NUM_TID'(1) << tid;
  assign reg_ok           = bus.ld_rsp_reg < REG_W'(NUM_REGS);
  assign bus.ld_rsp_ready = rst_n && !(&vld);
  assign accept           = bus.ld_rsp_valid && bus.ld_rsp_ready;

  // Oldest valid entry wins the drain slot; strict '>' keeps ties on the lowest index.
  always_comb begin
    has_sel = 1'b0;
    sel     = '0;
    sel_age = '0;
    ripe    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ages[i] >= AGE_W'(HOLD - 1))) ripe = 1'b1;
      if (vld[i] && (!has_sel || (ages[i] > sel_age))) begin
        has_sel = 1'b1;
        sel     = IDX_W'(i);
        sel_age = ages[i];
      end
    end
    drain_en = ripe || (flush && has_sel) || (&vld);
  end

  // An entry leaving this cycle must not absorb the response, so it allocates fresh instead.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && vld[i] && (regs[i] == bus.ld_rsp_reg) &&
          !(drain_en && (sel == IDX_W'(i)))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!has_free && !vld[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    do_merge = accept && reg_ok && hit;
    do_alloc = accept && reg_ok && !hit && has_free;
    cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_nxt[i] = (vld[i] && !(drain_en && (sel == IDX_W'(i)))) ||
                   (do_alloc && (free_idx == IDX_W'(i)));
      cnt_nxt    = cnt_nxt + CNT_W'(vld_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld               <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_tid_bitmap <= '0;
      bus.ld_dest_reg   <= '0;
      pending_cnt       <= '0;
      idle              <= 1'b1;
      bad_reg           <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]    <= '0;
        bitmaps[i] <= '0;
        ages[i]    <= '0;
      end
    end else begin
      vld <= vld_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (do_alloc && (free_idx == IDX_W'(i))) begin
          regs[i]    <= bus.ld_rsp_reg;
          bitmaps[i] <= tid_bit;
          ages[i]    <= '0;
        end else begin
          if (vld[i] && (ages[i] != AGE_W'(HOLD))) ages[i] <= ages[i] + 1'b1;
          if (do_merge && (hit_idx == IDX_W'(i))) bitmaps[i] <= bitmaps[i] | tid_bit;
        end
      end
      bus.wb_valid <= drain_en;
      if (drain_en) begin
        bus.wb_tid_bitmap <= bitmaps[sel];
        bus.ld_dest_reg   <= regs[sel];
      end
      pending_cnt <= cnt_nxt;
      idle        <= (cnt_nxt == '0) && !drain_en;
      if (accept && !reg_ok) bad_reg <= 1'b1;
    end
  end
endmodule
